// File: rtl/wb_timer_pkg.sv
// -----------------------------------------------------------------------------
// wb_timer_pkg
// Shared constants for the Wishbone machine timer: register word offsets
// (bus address bits [4:2]) and the CTRL enable bit position.
// -----------------------------------------------------------------------------
package wb_timer_pkg;

    // Register word offsets
    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CTRL        = 3'd4;

    // CTRL.EN bit index and the byte lane that carries it
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_EN_BYTE = CTRL_EN_BIT / 8;

    // Width of the prescaler counter (PRESCALE is at most 65535)
    localparam int PRESCALE_W = 16;

endpackage : wb_timer_pkg

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock by PRESCALE while enabled. The counter runs
// 0..PRESCALE-1 and wraps; tick is high for the single cycle in which the
// counter sits at its last value, i.e. the cycle whose edge performs the wrap.
// With PRESCALE=1 tick is high in every enabled cycle.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the counter
//   en    : count enable; the counter holds while low
//   clr   : synchronous clear of the counter (has priority over en)
//   tick  : one-cycle pulse on each wrap
// -----------------------------------------------------------------------------
module timer_prescaler
    import wb_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] CNT_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_reg;
    logic [PRESCALE_W-1:0] cnt_next;
    logic                  at_last;

    assign at_last = (cnt_reg == CNT_LAST);
    assign tick    = en & at_last;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = at_last ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule : timer_prescaler

// File: rtl/wb_timer.sv
// -----------------------------------------------------------------------------
// wb_timer
// Wishbone classic slave exposing a 64-bit RISC-V style machine timer
// (mtime / mtimecmp) with a prescaler and a level-sensitive interrupt.
//
// Parameters
//   PRESCALE : clock cycles per mtime increment (1..65535)
//
// Ports
//   wb_clk_i  : clock
//   wb_rst_i  : synchronous active-high reset
//   wb_adr_i  : word offset (bus address bits [4:2])
//   wb_dat_i  : write data
//   wb_sel_i  : byte enables, bit n enables byte n
//   wb_we_i   : write enable
//   wb_cyc_i  : bus cycle
//   wb_stb_i  : strobe
//   wb_dat_o  : registered read data, non-zero only while wb_ack_o is high
//   wb_ack_o  : one-cycle transfer acknowledge
//   wb_err_o  : always 0
//   irq_o     : registered (mtime >= mtimecmp)
//
// Register map: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
// 4 CTRL (bit0 EN), 5..7 unmapped (read 0, writes dropped).
// -----------------------------------------------------------------------------
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
)
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    logic        ack_reg,    ack_next;
    logic [31:0] dat_reg,    dat_next;
    logic [63:0] mtime_reg,  mtime_next;
    logic [63:0] cmp_reg,    cmp_next;
    logic        en_reg,     en_next;
    logic [31:0] shadow_reg, shadow_next;
    logic        irq_reg,    irq_next;

    logic        req;
    logic        wr;
    logic        rd;
    logic        tick;
    logic        clr;
    logic [31:0] byte_mask;
    logic [31:0] mtime_lo_wr;
    logic [31:0] mtime_hi_wr;
    logic [31:0] cmp_lo_wr;
    logic [31:0] cmp_hi_wr;

    // A request is accepted on the edge that raises ack; the ~ack term makes
    // a held strobe produce an ack every second cycle.
    assign req = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign wr  = req &  wb_we_i;
    assign rd  = req & ~wb_we_i;

    // Expand byte enables to a bit mask
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
        end
    endgenerate

    // Byte-merged write values for each writable word
    assign mtime_lo_wr = (mtime_reg[31:0]  & ~byte_mask) | (wb_dat_i & byte_mask);
    assign mtime_hi_wr = (mtime_reg[63:32] & ~byte_mask) | (wb_dat_i & byte_mask);
    assign cmp_lo_wr   = (cmp_reg[31:0]    & ~byte_mask) | (wb_dat_i & byte_mask);
    assign cmp_hi_wr   = (cmp_reg[63:32]   & ~byte_mask) | (wb_dat_i & byte_mask);

    // Writing EN=0 restarts the prescaler phase from zero
    assign clr = wr & (wb_adr_i == CTRL) & wb_sel_i[CTRL_EN_BYTE]
               & ~wb_dat_i[CTRL_EN_BIT];

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .en   (en_reg),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        ack_next    = req;
        dat_next    = '0;
        mtime_next  = mtime_reg + 64'(tick);
        cmp_next    = cmp_reg;
        en_next     = en_reg;
        shadow_next = shadow_reg;

        // A write to either mtime half replaces the tick for that cycle:
        // the other half is kept as-is, without increment or carry.
        if (wr) begin
            case (wb_adr_i)
                MTIME_LO:    mtime_next = {mtime_reg[63:32], mtime_lo_wr};
                MTIME_HI:    mtime_next = {mtime_hi_wr, mtime_reg[31:0]};
                MTIMECMP_LO: cmp_next   = {cmp_reg[63:32], cmp_lo_wr};
                MTIMECMP_HI: cmp_next   = {cmp_hi_wr, cmp_reg[31:0]};
                CTRL: begin
                    if (wb_sel_i[CTRL_EN_BYTE]) begin
                        en_next = wb_dat_i[CTRL_EN_BIT];
                    end
                end
                default: ;
            endcase
        end

        // Reading LO latches HI so a following HI read matches this LO value
        if (rd) begin
            case (wb_adr_i)
                MTIME_LO: begin
                    dat_next    = mtime_reg[31:0];
                    shadow_next = mtime_reg[63:32];
                end
                MTIME_HI:    dat_next = shadow_reg;
                MTIMECMP_LO: dat_next = cmp_reg[31:0];
                MTIMECMP_HI: dat_next = cmp_reg[63:32];
                CTRL:        dat_next = {31'd0, en_reg};
                default:     dat_next = '0;
            endcase
        end

        // Compare on the values that will be registered this edge
        irq_next = (mtime_next >= cmp_next);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg    <= 1'b0;
            dat_reg    <= '0;
            mtime_reg  <= '0;
            cmp_reg    <= '1;
            en_reg     <= 1'b1;
            shadow_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            ack_reg    <= ack_next;
            dat_reg    <= dat_next;
            mtime_reg  <= mtime_next;
            cmp_reg    <= cmp_next;
            en_reg     <= en_next;
            shadow_reg <= shadow_next;
            irq_reg    <= irq_next;
        end
    end

    assign wb_ack_o = ack_reg;
    assign wb_dat_o = dat_reg;
    assign wb_err_o = 1'b0;
    assign irq_o    = irq_reg;

endmodule : wb_timer

// File: tb/tb_wb_timer.sv
// -----------------------------------------------------------------------------
// tb_wb_timer
// Two timer instances (PRESCALE=1 and PRESCALE=4) share one bus. A reference
// model of the timer registers predicts each transfer at the clock edge that
// accepts it and queues the expected read data; a negedge monitor pops and
// compares on every ack and checks ack, idle data, irq and err each cycle.
// Directed sequences add fixed expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;

    logic [1:0][31:0] dat_o;
    logic [1:0]       ack_o;
    logic [1:0]       err_o;
    logic [1:0]       irq_o;

    int checks   = 0;
    int failures = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    wb_timer #(.PRESCALE(1)) u_dut_p1 (
        .wb_clk_i (clk),  .wb_rst_i (rst),  .wb_adr_i (adr),
        .wb_dat_i (wdat), .wb_sel_i (sel),  .wb_we_i  (we),
        .wb_cyc_i (cyc),  .wb_stb_i (stb),  .wb_dat_o (dat_o[0]),
        .wb_ack_o (ack_o[0]), .wb_err_o (err_o[0]), .irq_o (irq_o[0])
    );

    wb_timer #(.PRESCALE(4)) u_dut_p4 (
        .wb_clk_i (clk),  .wb_rst_i (rst),  .wb_adr_i (adr),
        .wb_dat_i (wdat), .wb_sel_i (sel),  .wb_we_i  (we),
        .wb_cyc_i (cyc),  .wb_stb_i (stb),  .wb_dat_o (dat_o[1]),
        .wb_ack_o (ack_o[1]), .wb_err_o (err_o[1]), .irq_o (irq_o[1])
    );

    // ---------------- reference model ----------------
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_en    [2];
    int          m_pcnt  [2];
    logic [31:0] m_shadow[2];
    logic        m_irq   [2];
    logic        m_ack;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    function automatic int ps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic        mreq;
        logic        tk;
        logic [63:0] t, nt, c;
        logic        e;
        int          p, np;
        logic [31:0] sh, rdata;
        if (rst) begin
            m_ack = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_mtime[i] = 64'd0;  m_cmp[i] = {64{1'b1}};  m_en[i] = 1'b1;
                m_pcnt[i] = 0;  m_shadow[i] = 32'd0;  m_irq[i] = 1'b0;
            end
        end else begin
            mreq = cyc && stb && !m_ack;
            for (int i = 0; i < 2; i++) begin
                t = m_mtime[i];  c = m_cmp[i];  e = m_en[i];
                p = m_pcnt[i];   sh = m_shadow[i];  rdata = 32'd0;
                tk = e && (p == ps(i) - 1);
                nt = tk ? t + 64'd1 : t;
                np = e ? (tk ? 0 : p + 1) : p;
                if (mreq && we) begin
                    case (adr)
                        3'd0: nt = {t[63:32], bmerge(t[31:0], wdat, sel)};
                        3'd1: nt = {bmerge(t[63:32], wdat, sel), t[31:0]};
                        3'd2: c  = {c[63:32], bmerge(c[31:0], wdat, sel)};
                        3'd3: c  = {bmerge(c[63:32], wdat, sel), c[31:0]};
                        3'd4: if (sel[0]) begin
                                  e = wdat[0];
                                  if (!wdat[0]) np = 0;
                              end
                        default: ;
                    endcase
                end
                if (mreq && !we) begin
                    case (adr)
                        3'd0: begin rdata = t[31:0]; sh = t[63:32]; end
                        3'd1: rdata = m_shadow[i];
                        3'd2: rdata = m_cmp[i][31:0];
                        3'd3: rdata = m_cmp[i][63:32];
                        3'd4: rdata = {31'd0, m_en[i]};
                        default: rdata = 32'd0;
                    endcase
                end
                m_mtime[i] = nt;  m_cmp[i] = c;  m_en[i] = e;
                m_pcnt[i] = np;   m_shadow[i] = sh;
                m_irq[i] = (nt >= c);
                if (mreq) begin
                    if (i == 0) exp_q0.push_back(rdata);
                    else        exp_q1.push_back(rdata);
                end
            end
            m_ack = mreq;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ack_o[i] !== m_ack) begin
                    failures++;
                    $display("FAIL ack[p%0d] actual=%b required=%b t=%0t", ps(i), ack_o[i], m_ack, $time);
                end
                if (ack_o[i] === 1'b1) begin
                    checks++;
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        failures++;
                        $display("FAIL unexpected_ack[p%0d] actual=ack required=no_ack t=%0t", ps(i), $time);
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (dat_o[i] !== e) begin
                            failures++;
                            $display("FAIL rdata[p%0d] actual=%h required=%h t=%0t", ps(i), dat_o[i], e, $time);
                        end
                    end
                end else begin
                    checks++;
                    if (dat_o[i] !== 32'd0) begin
                        failures++;
                        $display("FAIL idle_dat[p%0d] actual=%h required=00000000 t=%0t", ps(i), dat_o[i], $time);
                    end
                end
                checks++;
                if (irq_o[i] !== m_irq[i]) begin
                    failures++;
                    $display("FAIL irq[p%0d] actual=%b required=%b t=%0t", ps(i), irq_o[i], m_irq[i], $time);
                end
                checks++;
                if (err_o[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL err[p%0d] actual=%b required=0 t=%0t", ps(i), err_o[i], $time);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r0, output logic [31:0] r1);
        int n;
        @(negedge clk);
        adr = a;  we = w;  wdat = d;  sel = s;  cyc = 1'b1;  stb = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_o[0] !== 1'b1 && n < 20);
        if (ack_o[0] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack adr=%0d", a);
        end
        r0 = dat_o[0];
        r1 = dat_o[1];
        $display("xfer %s adr=%0d sel=%h wdat=%h -> p1=%h p4=%h", w ? "WR" : "RD", a, s, d, r0, r1);
        cyc = 1'b0;  stb = 1'b0;  we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r0, r1;
        xfer(a, 1'b1, d, s, r0, r1);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
        xfer(a, 1'b0, 32'd0, 4'hF, r0, r1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        logic [31:0] r0, r1;
        int acks, n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        rst = 1'b0;

        // Reset defaults
        rd(3'd0, r0, r1);
        rd(3'd1, r0, r1);  chk("rst_hi_p1", r0, 32'h0);        chk("rst_hi_p4", r1, 32'h0);
        rd(3'd2, r0, r1);  chk("rst_cmplo_p1", r0, 32'hFFFF_FFFF); chk("rst_cmplo_p4", r1, 32'hFFFF_FFFF);
        rd(3'd3, r0, r1);  chk("rst_cmphi_p1", r0, 32'hFFFF_FFFF); chk("rst_cmphi_p4", r1, 32'hFFFF_FFFF);
        rd(3'd4, r0, r1);  chk("rst_ctrl_p1", r0, 32'h1);       chk("rst_ctrl_p4", r1, 32'h1);
        chk("rst_irq", {30'd0, irq_o}, 32'h0);

        // Carry LO -> HI: two ticks after LO=FFFFFFFE on the PRESCALE=1 timer
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        @(negedge clk);
        rd(3'd0, r0, r1);  chk("carry_lo_p1", r0, 32'h0);
        rd(3'd1, r0, r1);  chk("carry_hi_p1", r0, 32'h1);

        // Prescaler and EN on the PRESCALE=4 timer
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h1, 4'hF);
        repeat (19) @(negedge clk);
        rd(3'd0, r0, r1);  chk("prescale_20cyc_p4", r1, 32'd5);
        wr(3'd4, 32'h0, 4'hF);
        repeat (50) @(negedge clk);
        rd(3'd0, r0, r1);  chk("en0_hold_p4", r1, 32'd5);

        // Interrupt rise and clear
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd2, 32'd10, 4'hF);
        chk("irq_low_before_run", {30'd0, irq_o}, 32'h0);
        wr(3'd4, 32'h1, 4'hF);
        n = 0;
        while (irq_o !== 2'b11 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("irq_rise", {30'd0, irq_o}, 32'h3);
        wr(3'd2, 32'd100, 4'hF);
        chk("irq_clear", {30'd0, irq_o}, 32'h0);

        // Byte enables and write/tick collision
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'h1122_3344, 4'hF);
        wr(3'd0, 32'hAABB_CCDD, 4'b0100);
        rd(3'd0, r0, r1);  chk("bytesel_p1", r0, 32'h11BB_3344); chk("bytesel_p4", r1, 32'h11BB_3344);
        wr(3'd4, 32'h1, 4'hF);
        wr(3'd0, 32'h1234_5678, 4'hF);
        wr(3'd4, 32'h0, 4'hF);
        rd(3'd0, r0, r1);

        // Held strobe: acks on alternate cycles
        @(negedge clk);
        adr = 3'd4;  we = 1'b0;  sel = 4'hF;  cyc = 1'b1;  stb = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_o[0] === 1'b1) acks++;
        end
        cyc = 1'b0;  stb = 1'b0;
        chk("held_stb_acks", acks, 32'd3);
        rd(3'd7, r0, r1);  chk("unmapped7_p1", r0, 32'h0); chk("unmapped7_p4", r1, 32'h0);
        rd(3'd5, r0, r1);  chk("unmapped5_p1", r0, 32'h0);
        // stb without cyc is ignored
        @(negedge clk);
        stb = 1'b1;  cyc = 1'b0;  we = 1'b1;  adr = 3'd0;  wdat = 32'hDEAD_0000;
        @(negedge clk);
        chk("stb_no_cyc", {30'd0, ack_o}, 32'h0);
        stb = 1'b0;  we = 1'b0;

        // Reset during an in-flight write: no ack, no commit
        @(negedge clk);
        adr = 3'd0;  we = 1'b1;  wdat = 32'hDEAD_BEEF;  sel = 4'hF;  cyc = 1'b1;  stb = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_ack", {30'd0, ack_o}, 32'h0);
        cyc = 1'b0;  stb = 1'b0;  we = 1'b0;
        rst = 1'b0;
        rd(3'd2, r0, r1);  chk("rst_abort_cmp", r0, 32'hFFFF_FFFF);

        // Randomised traffic against the model
        for (int k = 0; k < 300; k++) begin
            logic [2:0]  a;
            logic [3:0]  s;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            d = $urandom;
            if (a == 3'd1 || a == 3'd3) d = 32'($urandom_range(0, 3));
            if (a == 3'd4) d = 32'($urandom_range(0, 7) != 0);
            xfer(a, 1'($urandom_range(0, 1)), d, s, r0, r1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_p1_empty", 32'(exp_q0.size()), 32'd0);
        chk("queue_p4_empty", 32'(exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_timer
